// File: rtl/seq_smul_unit_pkg.sv
// seq_smul_unit_pkg: shared state encodings and default width for the sequential SMUL unit.
package seq_smul_unit_pkg;
   localparam int SMUL_WIDTH = 16;
   typedef enum logic [1:0] {
      SMUL_IDLE = 2'd0,
      SMUL_RUN  = 2'd1,
      SMUL_DONE = 2'd2
   } smul_state_t;
endpackage

// File: rtl/seq_smul_unit_booth_step.sv
// booth_step: one radix-2 Booth iteration on {acc, q, q_1}, followed by an arithmetic shift right.
module booth_step #(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH:0]   i_acc,
   input  logic [WIDTH-1:0] i_q,
   input  logic             i_q1,
   input  logic [WIDTH-1:0] i_m,
   output logic [WIDTH:0]   o_acc,
   output logic [WIDTH-1:0] o_q,
   output logic             o_q1
);
   logic [WIDTH:0] w_m;
   logic [WIDTH:0] w_sum;
   assign w_m = {i_m[WIDTH-1], i_m};
   always_comb begin
      w_sum = ({i_q[0], i_q1} == 2'b01) ? i_acc + w_m :
              ({i_q[0], i_q1} == 2'b10) ? i_acc - w_m : i_acc;
      o_acc = {w_sum[WIDTH], w_sum[WIDTH:1]};
      o_q   = {w_sum[0], i_q[WIDTH-1:1]};
      o_q1  = i_q[0];
   end
endmodule

// File: rtl/seq_smul_unit.sv
// seq_smul_unit: multi-cycle signed WIDTH x WIDTH Booth multiplier returning the product as two halves.
module seq_smul_unit
   import seq_smul_unit_pkg::*;
#(
   parameter int WIDTH = SMUL_WIDTH,
   parameter int CNT_W = 5
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             iStart,
   input  logic [WIDTH-1:0] iOperandA,
   input  logic [WIDTH-1:0] iOperandB,
   output logic             oBusy,
   output logic             oDone,
   output logic [WIDTH-1:0] oResultLow,
   output logic [WIDTH-1:0] oResultHigh,
   output logic             oWriteEnable
);
   smul_state_t      r_state, w_next_state;
   logic [CNT_W-1:0] r_cnt;
   logic [WIDTH:0]   r_acc, w_acc;
   logic [WIDTH-1:0] r_q, w_q, r_m;
   logic             r_q1, w_q1, w_last;

   booth_step #(.WIDTH(WIDTH)) u_step (
      .i_acc(r_acc), .i_q(r_q), .i_q1(r_q1), .i_m(r_m),
      .o_acc(w_acc), .o_q(w_q), .o_q1(w_q1)
   );

   assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         SMUL_IDLE: w_next_state = iStart ? SMUL_RUN : SMUL_IDLE;
         SMUL_RUN:  w_next_state = w_last ? SMUL_DONE : SMUL_RUN;
         default:   w_next_state = SMUL_IDLE;
      endcase
   end

   // The product is captured from the final step so it is already valid while oDone is high.
   always_ff @(posedge Clock) begin
      if (!Reset) begin
         r_state     <= SMUL_IDLE;
         r_cnt       <= '0;
         r_acc       <= '0;
         r_q         <= '0;
         r_q1        <= 1'b0;
         r_m         <= '0;
         oResultLow  <= '0;
         oResultHigh <= '0;
      end else begin
         r_state <= w_next_state;
         if (r_state == SMUL_IDLE && iStart) begin
            r_m   <= iOperandA;
            r_q   <= iOperandB;
            r_acc <= '0;
            r_q1  <= 1'b0;
            r_cnt <= '0;
         end else if (r_state == SMUL_RUN) begin
            r_acc <= w_acc;
            r_q   <= w_q;
            r_q1  <= w_q1;
            r_cnt <= r_cnt + 1'b1;
            if (w_last) begin
               oResultHigh <= w_acc[WIDTH-1:0];
               oResultLow  <= w_q;
            end
         end
      end
   end

   assign oBusy        = (r_state == SMUL_RUN);
   assign oDone        = (r_state == SMUL_DONE);
   assign oWriteEnable = oDone;
endmodule

// File: tb/tb_seq_smul_unit.sv
// tb_seq_smul_unit: table-driven and randomized checks of seq_smul_unit against plain signed multiplication.
module tb_seq_smul_unit;
   logic        Clock = 1'b0;
   logic        Reset = 1'b0;
   logic        iStart = 1'b0;
   logic [15:0] iOperandA = '0, iOperandB = '0;
   logic        oBusy, oDone, oWriteEnable;
   logic [15:0] oResultLow, oResultHigh;

   int tests = 0, fails = 0, cyc = 0;

   seq_smul_unit dut (
      .Clock(Clock), .Reset(Reset), .iStart(iStart),
      .iOperandA(iOperandA), .iOperandB(iOperandB),
      .oBusy(oBusy), .oDone(oDone), .oResultLow(oResultLow),
      .oResultHigh(oResultHigh), .oWriteEnable(oWriteEnable)
   );

   always #5 Clock = ~Clock;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic [31:0] p;
   } vec_t;

   function automatic logic [31:0] model(logic [15:0] a, logic [15:0] b);
      longint pa, pb;
      pa = longint'($signed(a));
      pb = longint'($signed(b));
      return 32'(pa * pb);
   endfunction

   function automatic void chk(string n, logic [31:0] got, logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", n, got, exp);
      end
   endfunction

   task automatic tick;
      @(posedge Clock);
      #1;
      cyc++;
   endtask

   task automatic start_op(input logic [15:0] a, input logic [15:0] b);
      iStart = 1'b1;
      iOperandA = a;
      iOperandB = b;
      tick();
      iStart = 1'b0;
      iOperandA = $urandom;
      iOperandB = $urandom;
   endtask

   task automatic wait_done(output int lat, output int busy);
      lat = 1;
      busy = 0;
      while (!oDone && lat < 40) begin
         if (oBusy) busy++;
         tick();
         lat++;
      end
   endtask

   task automatic run_check(input string n, input logic [15:0] a, input logic [15:0] b, input logic [31:0] p);
      int lat, busy;
      start_op(a, b);
      wait_done(lat, busy);
      chk({n, " latency"}, lat, 17);
      chk({n, " busy"}, busy, 16);
      chk({n, " result"}, {oResultHigh, oResultLow}, p);
      chk({n, " we"}, oWriteEnable, 1'b1);
      tick();
      chk({n, " done_pulse"}, {oDone, oBusy}, 2'b00);
      chk({n, " hold"}, {oResultHigh, oResultLow}, p);
   endtask

   initial begin
      vec_t vt[6];
      int lat, busy, dones, last_done;
      logic [31:0] cap;
      logic [15:0] ra, rb;
      vt[0] = '{16'h0007, 16'h0003, 32'h0000_0015};
      vt[1] = '{16'h8000, 16'h8000, 32'h4000_0000};
      vt[2] = '{16'hFFFF, 16'h0005, 32'hFFFF_FFFB};
      vt[3] = '{16'h8000, 16'h0001, 32'hFFFF_8000};
      vt[4] = '{16'h0000, 16'h1234, 32'h0000_0000};
      vt[5] = '{16'h7FFF, 16'h8000, 32'hC000_8000};

      tick();
      tick();
      Reset = 1'b1;
      for (int i = 0; i < 5; i++) begin
         chk("reset_idle", {oBusy, oDone, oWriteEnable, oResultHigh, oResultLow}, '0);
         tick();
      end

      for (int i = 0; i < 6; i++) run_check($sformatf("vec%0d", i), vt[i].a, vt[i].b, vt[i].p);

      for (int i = 0; i < 6; i++) begin
         ra = 16'($urandom);
         rb = 16'($urandom);
         run_check($sformatf("rand%0d", i), ra, rb, model(ra, rb));
      end

      start_op(16'h1234, 16'h5678);
      dones = 0;
      cap = '0;
      for (int i = 1; i < 30; i++) begin
         if (i == 5) begin
            iStart = 1'b1;
            iOperandA = 16'h0002;
            iOperandB = 16'h0002;
         end else iStart = 1'b0;
         if (oDone) begin
            dones++;
            cap = {oResultHigh, oResultLow};
         end
         tick();
      end
      chk("ignored_start dones", dones, 1);
      chk("ignored_start result", cap, 32'h0626_0060);

      start_op(16'h7FFF, 16'h7FFF);
      for (int i = 1; i < 8; i++) tick();
      Reset = 1'b0;
      tick();
      chk("abort outputs", {oBusy, oDone, oWriteEnable, oResultHigh, oResultLow}, '0);
      Reset = 1'b1;
      dones = 0;
      for (int i = 0; i < 25; i++) begin
         if (oDone) dones++;
         tick();
      end
      chk("abort no_done", dones, 0);
      run_check("after_abort", 16'h0002, 16'hFFFE, 32'hFFFF_FFFC);

      last_done = 0;
      for (int i = 0; i < 3; i++) begin
         ra = 16'($urandom);
         rb = 16'($urandom);
         start_op(ra, rb);
         wait_done(lat, busy);
         chk($sformatf("b2b%0d result", i), {oResultHigh, oResultLow}, model(ra, rb));
         if (i > 0) chk($sformatf("b2b%0d spacing", i), cyc - last_done, 18);
         last_done = cyc;
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
